// File: rtl/reg_file_if.sv
// Operand-fetch and write-back bus between the RV32I pipeline and its register file.
// The pipeline takes the master side; the register file takes the slave side.
interface reg_file_if #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
);

   logic [ADDR_W-1:0] i_rd_addr_0;
   logic [ADDR_W-1:0] i_rd_addr_1;
   logic [ADDR_W-1:0] i_wr_addr;
   logic              i_wr_en;
   logic [XLEN-1:0]   i_wr_dat;
   logic [XLEN-1:0]   o_rd_dat_0;
   logic [XLEN-1:0]   o_rd_dat_1;

   modport master (
      output i_rd_addr_0,
      output i_rd_addr_1,
      output i_wr_addr,
      output i_wr_en,
      output i_wr_dat,
      input  o_rd_dat_0,
      input  o_rd_dat_1
   );

   modport slave (
      input  i_rd_addr_0,
      input  i_rd_addr_1,
      input  i_wr_addr,
      input  i_wr_en,
      input  i_wr_dat,
      output o_rd_dat_0,
      output o_rd_dat_1
   );

endinterface

// File: rtl/reg_file.sv
// RV32I integer register file: 2**ADDR_W x XLEN, two combinational read ports,
// one synchronous write port, plus a combinational debug read port. x0 reads as zero.
module reg_file #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   reg_file_if.slave         bus,
   input  logic [ADDR_W-1:0] top_regfile_addr,
   output logic [XLEN-1:0]   top_regfile_data
);

   localparam int NREGS = 2 ** ADDR_W;

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_accept;

   assign wr_accept = bus.i_wr_en && (bus.i_wr_addr != '0);

   // Entry 0 is cleared by reset and never written, so it folds to a constant zero.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_accept) begin
         regs[bus.i_wr_addr] <= bus.i_wr_dat;
      end
   end

   // No write bypass: a read of the write target shows the old value until the edge.
   assign bus.o_rd_dat_0 = (bus.i_rd_addr_0 == '0) ? '0 : regs[bus.i_rd_addr_0];
   assign bus.o_rd_dat_1 = (bus.i_rd_addr_1 == '0) ? '0 : regs[bus.i_rd_addr_1];
   assign top_regfile_data = (top_regfile_addr == '0) ? '0 : regs[top_regfile_addr];

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed reset/write/x0/boundary cases, then
// randomized traffic with occasional asynchronous resets, checked against an array model.
module tb_reg_file;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 5;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [ADDR_W-1:0] top_regfile_addr;
   logic [XLEN-1:0]   top_regfile_data;

   logic [XLEN-1:0] model [32];
   int errorCount = 0;
   int checkCount = 0;

   reg_file_if #(.XLEN(XLEN), .ADDR_W(ADDR_W)) rf_bus ();

   reg_file #(.XLEN(XLEN), .ADDR_W(ADDR_W)) dut (
      .clk              (clk),
      .rst              (rst),
      .bus              (rf_bus.slave),
      .top_regfile_addr (top_regfile_addr),
      .top_regfile_data (top_regfile_data)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                              input logic [XLEN-1:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic clearModel();
      for (int i = 0; i < 32; i++) model[i] = '0;
   endtask

   // Every readable port is compared with the architectural value of its register.
   task automatic checkReads(input string tag);
      checkOutput({tag, ".rd0"}, rf_bus.o_rd_dat_0, model[rf_bus.i_rd_addr_0]);
      checkOutput({tag, ".rd1"}, rf_bus.o_rd_dat_1, model[rf_bus.i_rd_addr_1]);
      checkOutput({tag, ".dbg"}, top_regfile_data, model[top_regfile_addr]);
   endtask

   // Called at a falling edge: drives one cycle, checks before and after the rising edge.
   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra0, input logic [4:0] ra1,
                                input logic [4:0] dbg);
      rf_bus.i_wr_en    = we;
      rf_bus.i_wr_addr  = wa;
      rf_bus.i_wr_dat   = wd;
      rf_bus.i_rd_addr_0 = ra0;
      rf_bus.i_rd_addr_1 = ra1;
      top_regfile_addr  = dbg;
      #1;
      checkReads("pre");
      @(posedge clk);
      if (rst && we && wa != 5'd0) model[wa] = wd;
      @(negedge clk);
      checkReads("post");
   endtask

   // Asynchronous reset asserted mid low-phase with a write pending, released a cycle later.
   task automatic pulseReset();
      rf_bus.i_wr_en   = 1'b1;
      rf_bus.i_wr_addr = 5'($urandom_range(1, 31));
      rf_bus.i_wr_dat  = $urandom;
      #2;
      rst = 1'b0;
      clearModel();
      #1;
      checkReads("rstHeld");
      @(posedge clk);
      @(negedge clk);
      checkReads("rstAfterEdge");
      rst = 1'b1;
   endtask

   initial begin
      logic [4:0] wa;
      clearModel();
      rf_bus.i_wr_en     = 1'b0;
      rf_bus.i_wr_addr   = '0;
      rf_bus.i_wr_dat    = '0;
      rf_bus.i_rd_addr_0 = '0;
      rf_bus.i_rd_addr_1 = '0;
      top_regfile_addr   = '0;

      // Reset held: reads are zero and a pending write is ignored.
      #2 rst = 1'b0;
      #1;
      checkOutput("rst.rd0", rf_bus.o_rd_dat_0, 32'h0);
      checkOutput("rst.rd1", rf_bus.o_rd_dat_1, 32'h0);
      @(negedge clk);
      applyStimulus(1'b1, 5'd1, 32'hFFFF_FFFF, 5'd1, 5'd1, 5'd1);
      checkOutput("rstWrite.x1", rf_bus.o_rd_dat_0, 32'h0);

      $display("[TB] releasing reset");
      rst = 1'b1;
      applyStimulus(1'b1, 5'd1, 32'h1234_5678, 5'd1, 5'd1, 5'd1);
      checkOutput("basic.rd0", rf_bus.o_rd_dat_0, 32'h1234_5678);
      checkOutput("basic.rd1", rf_bus.o_rd_dat_1, 32'h1234_5678);
      applyStimulus(1'b0, 5'd1, 32'hFFFF_FFFF, 5'd1, 5'd1, 5'd1);
      checkOutput("noWrite.x1", rf_bus.o_rd_dat_0, 32'h1234_5678);

      applyStimulus(1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd0, 5'd0);
      checkOutput("x0.rd0", rf_bus.o_rd_dat_0, 32'h0);
      checkOutput("x0.rd1", rf_bus.o_rd_dat_1, 32'h0);
      checkOutput("x0.dbg", top_regfile_data, 32'h0);

      applyStimulus(1'b1, 5'd2, 32'hAAAA_AAAA, 5'd2, 5'd3, 5'd1);
      applyStimulus(1'b1, 5'd3, 32'h5555_5555, 5'd2, 5'd3, 5'd2);
      checkOutput("x2", rf_bus.o_rd_dat_0, 32'hAAAA_AAAA);
      checkOutput("x3", rf_bus.o_rd_dat_1, 32'h5555_5555);
      applyStimulus(1'b1, 5'd31, 32'hDEAD_BEEF, 5'd31, 5'd2, 5'd31);
      checkOutput("x31", rf_bus.o_rd_dat_0, 32'hDEAD_BEEF);
      applyStimulus(1'b1, 5'd15, 32'hCAFE_BABE, 5'd15, 5'd15, 5'd15);
      checkOutput("x15.fall", rf_bus.o_rd_dat_1, 32'hCAFE_BABE);

      // Reset recovery: written registers return to zero on every port.
      applyStimulus(1'b1, 5'd4, 32'h1111_1111, 5'd4, 5'd5, 5'd4);
      applyStimulus(1'b1, 5'd5, 32'h2222_2222, 5'd4, 5'd5, 5'd5);
      checkOutput("x5.set", rf_bus.o_rd_dat_1, 32'h2222_2222);
      rf_bus.i_rd_addr_0 = 5'd4;
      rf_bus.i_rd_addr_1 = 5'd5;
      top_regfile_addr   = 5'd4;
      pulseReset();
      checkOutput("recov.x4", rf_bus.o_rd_dat_0, 32'h0);
      checkOutput("recov.x5", rf_bus.o_rd_dat_1, 32'h0);
      checkOutput("recov.dbg", top_regfile_data, 32'h0);

      $display("[TB] randomized traffic");
      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 39) == 0) begin
            pulseReset();
         end else begin
            case ($urandom_range(0, 5))
               0:       wa = 5'd0;
               1:       wa = 5'd31;
               default: wa = 5'($urandom_range(0, 31));
            endcase
            applyStimulus(1'($urandom_range(0, 3) != 0), wa, $urandom,
                          ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)),
                          5'($urandom_range(0, 31)),
                          ($urandom_range(0, 2) == 0) ? wa : 5'($urandom_range(0, 31)));
         end
      end

      $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
      $finish;
   end

endmodule

// File: doc/reg_file.md
Name: reg_file

Overview:
- Integer register file for the RV32I core: 32 general-purpose registers x0..x31, 32 bits each.
- Two asynchronous (combinational) read ports feed operand fetch.
- One synchronous write port serves write-back.
- x0 is hardwired to zero.
- An extra combinational debug read port exposes any register to top-level debug/FPGA display logic.

Parameters:
- XLEN, 32, data width of each register and of all data ports.
- ADDR_W, 5, register address width; the register count is 2**ADDR_W = 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset: one clock; reset is asynchronous and active-low.
- i_rd_addr_0  input  5  read port 0 register index.
- i_rd_addr_1  input  5  read port 1 register index.
- i_wr_addr  input  5  write port register index.
- i_wr_en  input  1  write enable, sampled at the rising edge of clk.
- i_wr_dat  input  32  write data.
- o_rd_dat_0  output  32  contents of register i_rd_addr_0.
- o_rd_dat_1  output  32  contents of register i_rd_addr_1.
- top_regfile_addr  input  5  debug read index.
- top_regfile_data  output  32  contents of register top_regfile_addr (debug).

Behaviour:
- Storage: 32 x 32-bit flops. Register x0 is not stored, or is constant 0.
- Reset (rst low): asynchronously clears all registers x1..x31 to 0, with no clock required.
  - While reset is held, all read outputs show 0.
  - Reset overrides any pending write: with i_wr_en=1 during reset, no register is modified.
- Release: the first write is accepted at the first rising edge after rst goes high.
- Write: at the rising edge of clk, if rst is inactive, i_wr_en=1 and i_wr_addr!=0, then reg[i_wr_addr] <= i_wr_dat.
  - i_wr_en=0: no register changes, and i_wr_dat is ignored.
  - i_wr_addr=0: the write is silently discarded; x0 stays 0.
- Reads: purely combinational, zero latency.
  - o_rd_dat_0 = (i_rd_addr_0==0) ? 0 : reg[i_rd_addr_0]; o_rd_dat_1 likewise.
  - top_regfile_data likewise.
  - Both read ports may address the same or different registers simultaneously, including the write target.
- Read-during-write: there is no internal bypass.
  - Before the write edge, a read of the write target returns the old value.
  - Immediately after the edge, in the same cycle, it returns the new value.
  - Forwarding is the pipeline's responsibility.
- Back-to-back writes to different registers on consecutive edges are each committed independently.
- All addresses 0..31 are valid, including 31; no out-of-range case exists.
- No X propagation after reset: every readable location is defined.

Test Plan:
- Reset: hold rst low, all reads at addr 0 -> o_rd_dat_0/1 = 0. With rst low, wr_en=1, wr_addr=1, wr_dat=FFFFFFFF, apply a clock edge -> reads of x1 = 0.
- Basic write/read: release reset, write x1=12345678, then read both ports at x1 -> both 12345678. Next cycle wr_en=0 with wr_dat=FFFFFFFF -> x1 still 12345678.
- x0: write x0=FFFFFFFF with wr_en=1 -> reads of x0 on both ports and on the debug port = 0.
- Multiple registers and boundaries:
  - Write x2=AAAAAAAA, then x3=55555555; read port 0 at x2, port 1 at x3 -> AAAAAAAA / 55555555.
  - Write x31=DEADBEEF -> DEADBEEF.
  - Write x15=CAFEBABE; read x15 at the falling edge right after the write edge -> CAFEBABE.
- Reset recovery: write x4=11111111 and x5=22222222, then assert rst -> reads of x4 and x5 = 0. Confirm also that the debug port at x4 = 0.
